// File: rtl/seq_divider16_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_W   : default operand / result width
//   state_e : controller state encoding (IDLE -> RUN -> DONE -> IDLE)
package seq_divider16_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider16_div_sub_step.sv
// One trial-subtraction step of the restoring divider.
// Computes diff = a - b as a + ~b + 1 through a ripple of full-adder cells.
//   a, b      : WIDTH+1-bit unsigned operands
//   diff      : WIDTH+1-bit difference
//   no_borrow : carry out of the top cell; 1 means a >= b
module div_sub_step
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           no_borrow
);

  logic [WIDTH+1:0] carry;
  logic [WIDTH:0]   b_n;

  assign b_n      = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign diff[i]    = a[i] ^ b_n[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
  end

  assign no_borrow = carry[WIDTH+1];

endmodule

// File: rtl/seq_divider16.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : request, sampled only while idle
//   dividend    : numerator, captured on the accepting edge
//   divisor     : denominator, captured on the accepting edge
//   busy        : high whenever the controller is not idle
//   done        : one-cycle pulse, results valid while high
//   quotient    : result, held until replaced by the next completed operation
//   remainder   : result, held until replaced by the next completed operation
//   div_by_zero : set with done when divisor was zero, cleared by the next valid start
//
// Handshake: start is accepted on a rising edge only when busy=0. The accepting
// edge captures the operands; later operand changes and any start seen while
// busy=1 are ignored (no queuing). done pulses for exactly one cycle with the
// results valid, then the block returns to idle; a start held high is accepted
// again on the first idle edge.
module seq_divider16
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;        // partial remainder
  logic [WIDTH-1:0] q_q, q_d;        // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;    // captured divisor
  logic [CNT_W-1:0] cnt_q, cnt_d;    // steps remaining after the current one
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // After every step the partial remainder is below the divisor, so its top
  // bit is always zero and drops out when shifting in the next dividend bit.
  logic unused_r_msb;
  assign unused_r_msb = r_q[WIDTH];

  assign rs = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_sub_step (
    .a         (rs),
    .b         ({1'b0, dvs_q}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // Restore (keep the shifted value) when the trial subtraction borrowed.
  assign r_next = no_borrow ? diff : rs;
  assign q_next = {q_q[WIDTH-2:0], no_borrow};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d   = dividend;
          dvs_d = divisor;
          r_d   = '0;
          cnt_d = CNT_W'(WIDTH - 1);
          if (divisor == '0) begin
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            dbz_d   = 1'b0;
          end
        end
      end
      ST_RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          quot_d  = q_next;
          rem_d   = r_next[WIDTH-1:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
module tb_seq_divider16;

  localparam int W  = 16;
  localparam int EW = 2 * W + 1;   // {div_by_zero, quotient, remainder}

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[12];

  seq_divider16 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  // ---------------- driver tasks ----------------
  // Ends on the falling edge right after the accepting rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [EW-1:0] exp);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(exp);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Called on the falling edge after acceptance (k=0); expects done at k=exp_lat.
  // Ends on the falling edge after the done cycle.
  task automatic wait_done(input int exp_lat, input string tag);
    int lat;
    logic [EW-1:0] e;
    lat = -1;
    for (int k = 0; k <= W + 4; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      chk({tag, "_busy_run"}, 64'(busy), 64'd1);
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (lat >= 0) begin
      chk({tag, "_busy_done"}, 64'(busy), 64'd1);
      chk({tag, "_quotient"}, 64'(quotient), 64'(e[2*W-1:W]));
      chk({tag, "_remainder"}, 64'(remainder), 64'(e[W-1:0]));
      chk({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(e[2*W]));
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int extra;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,    1'b0};
    vecs[1]  = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,    1'b0};
    vecs[2]  = '{16'd3,     16'd10,     16'd0,      16'd3,    1'b0};
    vecs[3]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,    1'b0};
    vecs[4]  = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234, 1'b1};
    vecs[5]  = '{16'd100,   16'd7,      16'd14,     16'd2,    1'b0};
    vecs[6]  = '{16'd0,     16'd5,      16'd0,      16'd0,    1'b0};
    vecs[7]  = '{16'd65535, 16'd2,      16'd32767,  16'd1,    1'b0};
    vecs[8]  = '{16'd40000, 16'd256,    16'd156,    16'd64,   1'b0};
    vecs[9]  = '{16'd1000,  16'd1000,   16'd1,      16'd0,    1'b0};
    vecs[10] = '{16'd999,   16'd1000,   16'd0,      16'd999,  1'b0};
    vecs[11] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,    1'b1};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_div_by_zero", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b, {vecs[i].dbz, vecs[i].q, vecs[i].r});
      wait_done(vecs[i].dbz ? 0 : W, $sformatf("vec%0d", i));
    end

    // start pulsed during RUN is ignored.
    issue(16'd50, 16'd5, {1'b0, 16'd10, 16'd0});
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd9;
    divisor  = 16'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(W - 5, "ignore");
    extra = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) extra++;
      @(negedge clk);
    end
    chk("ignore_no_second_op", 64'(extra), 64'd0);

    // start held high: back-to-back operations, done spacing W+2.
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd50;
    divisor  = 16'd5;
    exp_q.push_back({1'b0, 16'd10, 16'd0});
    @(negedge clk);
    dividend = 16'd9;
    divisor  = 16'd3;
    exp_q.push_back({1'b0, 16'd3, 16'd0});
    wait_done(W, "hold1");
    @(negedge clk);
    start = 1'b0;
    wait_done(W, "hold2");

    // Reset mid-RUN aborts the operation.
    issue(16'd60000, 16'd7, {1'b0, 16'd8571, 16'd3});
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_div_by_zero", 64'(div_by_zero), 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    chk("abort_no_done", 64'(extra), 64'd0);
    chk("abort_quotient_held", 64'(quotient), 64'd0);
    issue(16'd60000, 16'd7, {1'b0, 16'd8571, 16'd3});
    wait_done(W, "after_abort");

    // Randomised pairs against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2, 3: rb = W'($urandom_range(1, 15));
        4:       rb = W'($urandom_range(1, 255));
        default: rb = W'($urandom);
      endcase
      issue(ra, rb, model(ra, rb));
      wait_done((rb == '0) ? 0 : W, "rand");
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
